// File: rtl/imem_loader_pkg.sv
// Shared constants and types for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned LD_STATE_W   = 3;
  localparam int unsigned LD_HDR_BYTES = 8;
  localparam int unsigned LD_HDR_CNT_W = 3;

  typedef enum logic [LD_STATE_W-1:0] {
    LD_IDLE = 3'd0,
    LD_HDR  = 3'd1,
    LD_DATA = 3'd2,
    LD_CSUM = 3'd3,
    LD_DONE = 3'd4,
    LD_ERR  = 3'd5
  } ld_state_e;

  // One-hot byte-enable bit for a lane within a 32-bit word.
  function automatic logic [3:0] lane_strb(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Assembles little-endian bytes into words and drives the registered RAM write port.
module imem_word_packer
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_accept,
  input  logic              i_last,
  input  logic [7:0]        i_byte,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [3:0]        o_wr_strb
);

  logic [DATA_W-1:0] r_acc;
  logic [3:0]        r_strb;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [3:0]        r_wr_strb;

  logic [1:0]        w_lane;
  logic [DATA_W-1:0] w_data;
  logic [3:0]        w_strb;
  logic              w_flush;

  // Merge the incoming byte into the current word; flush on lane 3 or the final byte.
  always_comb begin
    w_lane  = i_addr[1:0];
    w_data  = r_acc | (DATA_W'(i_byte) << {w_lane, 3'b000});
    w_strb  = r_strb | lane_strb(w_lane);
    w_flush = i_accept & ((w_lane == 2'd3) | i_last);
  end

  // Accumulator and write-port registers; a flush clears the accumulator in the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_strb    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_strb <= '0;
    end else begin
      r_wr_en <= w_flush;
      if (i_clear) begin
        r_acc  <= '0;
        r_strb <= '0;
      end else if (w_flush) begin
        r_wr_addr <= {i_addr[ADDR_W-1:2], 2'b00};
        r_wr_data <= w_data;
        r_wr_strb <= w_strb;
        r_acc     <= '0;
        r_strb    <= '0;
      end else if (i_accept) begin
        r_acc  <= w_data;
        r_strb <= w_strb;
      end
    end
  end

  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_wr_strb = r_wr_strb;

endmodule

// File: rtl/imem_loader.sv
// Loads an instruction image from a byte stream into instruction RAM while holding the core.
// Stream: 4-byte LE base address, 4-byte LE length, payload bytes.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [3:0]        wr_strb,
  output logic              core_hold,
  output logic              done,
  output logic              err
);

  ld_state_e               r_state;
  logic [LD_HDR_CNT_W-1:0] r_hdr_cnt;
  logic [55:0]             r_hdr;
  logic [ADDR_W-1:0]       r_cur_addr;
  logic [31:0]             r_remain;
  logic                    r_in_ready;
  logic                    r_core_hold;
  logic                    r_done;
  logic                    r_err;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]              r_xor;
`endif

  logic        w_xfer;
  logic        w_data_acc;
  logic        w_last;
  logic        w_start_ok;
  logic [63:0] w_hdr_full;
  logic [31:0] w_base;
  logic [31:0] w_len;
  logic [32:0] w_end;
  logic [32:0] w_limit;

  // Handshake decode and header range checks on the completed 8-byte header.
  always_comb begin
    w_xfer     = in_valid & r_in_ready;
    w_data_acc = w_xfer & (r_state == LD_DATA);
    w_last     = (r_remain == 32'd1);
    w_start_ok = start & ((r_state == LD_IDLE) | (r_state == LD_DONE) | (r_state == LD_ERR));
    w_hdr_full = {in_data, r_hdr};
    w_base     = w_hdr_full[31:0];
    w_len      = w_hdr_full[63:32];
    w_end      = {1'b0, w_base} + {1'b0, w_len};
    w_limit    = 33'd1 << ADDR_W;
  end

  // Load sequencer with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LD_IDLE;
      r_hdr_cnt   <= '0;
      r_hdr       <= '0;
      r_cur_addr  <= '0;
      r_remain    <= '0;
      r_in_ready  <= 1'b0;
      r_core_hold <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_xor       <= '0;
`endif
    end else begin
      // Lags the state by one cycle so release follows the final write.
      r_core_hold <= (r_state == LD_HDR) | (r_state == LD_DATA) |
                     (r_state == LD_CSUM) | (r_state == LD_ERR);
      case (r_state)
        LD_IDLE, LD_DONE, LD_ERR: begin
          if (start) begin
            r_state    <= LD_HDR;
            r_in_ready <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_hdr_cnt  <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_xor      <= '0;
`endif
          end
        end
        LD_HDR: begin
          if (w_xfer) begin
            r_hdr     <= w_hdr_full[63:8];
            r_hdr_cnt <= LD_HDR_CNT_W'(r_hdr_cnt + 3'd1);
            if (r_hdr_cnt == LD_HDR_CNT_W'(LD_HDR_BYTES - 1)) begin
              r_cur_addr <= w_base[ADDR_W-1:0];
              r_remain   <= w_len;
              if ((w_base[1:0] != 2'b00) || (w_end > w_limit)) begin
                r_state    <= LD_ERR;
                r_in_ready <= 1'b0;
                r_err      <= 1'b1;
              end else if (w_len == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                r_state    <= LD_CSUM;
`else
                r_state    <= LD_DONE;
                r_in_ready <= 1'b0;
                r_done     <= 1'b1;
`endif
              end else begin
                r_state <= LD_DATA;
              end
            end
          end
        end
        LD_DATA: begin
          if (w_xfer) begin
            r_cur_addr <= ADDR_W'(r_cur_addr + 1'b1);
            r_remain   <= r_remain - 32'd1;
`ifdef LOADER_CHECKSUM_EN
            r_xor      <= r_xor ^ in_data;
`endif
            if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
              r_state    <= LD_CSUM;
`else
              r_state    <= LD_DONE;
              r_in_ready <= 1'b0;
              r_done     <= 1'b1;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        LD_CSUM: begin
          if (w_xfer) begin
            r_in_ready <= 1'b0;
            if (in_data == r_xor) begin
              r_state <= LD_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= LD_ERR;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state    <= LD_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  imem_word_packer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_start_ok),
    .i_accept  (w_data_acc),
    .i_last    (w_last),
    .i_byte    (in_data),
    .i_addr    (r_cur_addr),
    .o_wr_en   (wr_en),
    .o_wr_addr (wr_addr),
    .o_wr_data (wr_data),
    .o_wr_strb (wr_strb)
  );

  assign in_ready  = r_in_ready;
  assign core_hold = r_core_hold;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a byte-address model predicts RAM writes and status.
module tb_imem_loader;

  localparam int unsigned AW = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strb;
  logic          core_hold;
  logic          done;
  logic          err;

  imem_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .core_hold (core_hold),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_wr_cyc = 0;
  int  hold_fall_cyc = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, act, expv);
    end
  endtask

  // Monitor: every write strobe pops the oldest expected write.
  initial begin : monitor
    wr_t g;
    wr_t e;
    logic prev_hold;
    prev_hold = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (wr_en) begin
        g = {wr_addr, wr_data, wr_strb};
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_write", 64'(g), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check(g == e, "write", 64'(g), 64'(e));
        end
      end
      if (prev_hold && !core_hold) hold_fall_cyc = cyc;
      prev_hold = core_hold;
    end
  end

  // Reference: group payload bytes by word address; returns header validity.
  task automatic model(input logic [31:0] base, input logic [31:0] len, input logic [7:0] pl[$], output bit hdr_ok);
    logic [31:0] a, w, cw, data;
    logic [3:0]  strb;
    bit          have;
    hdr_ok = (base[1:0] == 2'b00) && (({1'b0, base} + {1'b0, len}) <= (33'd1 << AW));
    if (!hdr_ok) return;
    have = 1'b0; cw = '0; data = '0; strb = '0;
    for (int i = 0; i < int'(len); i++) begin
      a = base + 32'(i);
      w = a & ~32'd3;
      if (!have || w != cw) begin
        if (have) exp_q.push_back({16'(cw), data, strb});
        cw = w; data = '0; strb = '0; have = 1'b1;
      end
      data = data | (32'(pl[i]) << (8 * a[1:0]));
      strb = strb | (4'd1 << a[1:0]);
    end
    if (have) exp_q.push_back({16'(cw), data, strb});
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int  n;
    bit  got;
    got = 1'b0;
    @(negedge clk);
    n = $urandom_range(gap, 0);
    if (n > 0) begin
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 50 && !got; k++) begin
      if (in_ready) begin
        @(posedge clk);
        got = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) check(1'b0, "in_ready_timeout", 64'(0), 64'(1));
  endtask

  task automatic send_header(input logic [31:0] base, input logic [31:0] len, input int gap);
    for (int i = 0; i < 4; i++) send_byte(8'(base >> (8 * i)), gap);
    for (int i = 0; i < 4; i++) send_byte(8'(len >> (8 * i)), gap);
  endtask

  task automatic run_load(input string tag, input logic [31:0] base, input logic [31:0] len,
                          input logic [7:0] pl[$], input logic [7:0] csum, input int gap);
    bit         ok;
    bit         exp_done;
    logic [7:0] x;
    model(base, len, pl, ok);
    pulse_start();
    send_header(base, len, gap);
    exp_done = 1'b0;
    if (ok) begin
      x = 8'h00;
      for (int i = 0; i < int'(len); i++) begin
        send_byte(pl[i], gap);
        x = x ^ pl[i];
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(csum, gap);
      exp_done = (csum == x);
`else
      exp_done = 1'b1;
      if (csum != x) exp_done = 1'b1;
`endif
    end
    @(negedge clk) in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check(done == exp_done, {tag, "_done"}, 64'(done), 64'(exp_done));
    check(err == !exp_done, {tag, "_err"}, 64'(err), 64'(!exp_done));
    check(core_hold == !exp_done, {tag, "_core_hold"}, 64'(core_hold), 64'(!exp_done));
    check(in_ready == 1'b0, {tag, "_in_ready"}, 64'(in_ready), 64'(0));
    check(exp_q.size() == 0, {tag, "_pending_writes"}, 64'(exp_q.size()), 64'(0));
  endtask

  function automatic logic [7:0] xor_of(input logic [7:0] pl[$]);
    logic [7:0] x;
    x = 8'h00;
    foreach (pl[i]) x = x ^ pl[i];
    return x;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [7:0]  pl[$];
    logic [7:0]  pl12[$];
    logic [7:0]  first4[$];
    logic [31:0] base;
    logic [31:0] len;
    bit          ok;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check({in_ready, wr_en, wr_addr, wr_data, wr_strb, core_hold, done, err} == '0,
          "reset_outputs", 64'({in_ready, wr_en, wr_addr, wr_data, wr_strb, core_hold, done, err}), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Aligned full load; core_hold must fall the cycle after the last write.
    pl = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h73, 8'h00, 8'h00, 8'h00};
    run_load("aligned", 32'h100, 32'd8, pl, xor_of(pl), 0);
    check(hold_fall_cyc - last_wr_cyc == 1, "core_hold_release", 64'(hold_fall_cyc - last_wr_cyc), 64'(1));

    // Partial tail word.
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_load("partial", 32'h0, 32'd6, pl, xor_of(pl), 0);

    // Header errors and empty load.
    pl = '{};
    run_load("misaligned", 32'h102, 32'd8, pl, 8'h00, 0);
    run_load("overrun", 32'((1 << AW) - 4), 32'd8, pl, 8'h00, 0);
    run_load("exact_end", 32'((1 << AW) - 4), 32'd4, '{8'hDE, 8'hAD, 8'hBE, 8'hEF}, 8'h22, 0);
    run_load("len_zero", 32'h40, 32'd0, pl, 8'h00, 0);

    // Same 12-byte payload, continuous then with random in_valid gaps.
    pl12 = '{};
    for (int i = 0; i < 12; i++) pl12.push_back(8'($urandom));
    run_load("stream", 32'h300, 32'd12, pl12, xor_of(pl12), 0);
    run_load("backpressure", 32'h300, 32'd12, pl12, xor_of(pl12), 3);

    // Reset after 5 payload bytes: only the first full word may be written.
    first4 = '{pl12[0], pl12[1], pl12[2], pl12[3]};
    model(32'h200, 32'd4, first4, ok);
    pulse_start();
    send_header(32'h200, 32'd12, 1);
    for (int i = 0; i < 5; i++) send_byte(pl12[i], 1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check({in_ready, wr_en, wr_addr, wr_data, wr_strb, core_hold, done, err} == '0,
          "midload_reset_outputs", 64'({in_ready, wr_en, wr_addr, wr_data, wr_strb, core_hold, done, err}), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check(exp_q.size() == 0, "midload_pending", 64'(exp_q.size()), 64'(0));
    check(core_hold == 1'b0, "midload_core_hold", 64'(core_hold), 64'(0));
    run_load("restart", 32'h200, 32'd12, pl12, xor_of(pl12), 1);

    // Randomized aligned loads of random length.
    for (int r = 0; r < 6; r++) begin
      len  = 32'($urandom_range(20, 1));
      base = 32'($urandom_range(16'hFF00, 0)) & ~32'd3;
      pl = '{};
      for (int i = 0; i < int'(len); i++) pl.push_back(8'($urandom));
      run_load("random", base, len, pl, xor_of(pl), $urandom_range(2, 0));
    end

`ifdef LOADER_CHECKSUM_EN
    pl = '{8'hAA, 8'h55};
    run_load("csum_good", 32'h40, 32'd2, pl, 8'hFF, 0);
    run_load("csum_bad", 32'h40, 32'd2, pl, 8'h00, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
